// File: rtl/wallace_mul8_sequencer_if.sv
// rtl/wallace_mul8_sequencer_if.sv - operand/result valid-ready bundle for wallace_mul8_sequencer
interface wallace_mul8_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_product;

   // operand source / result sink side
   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   // multiplier side
   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/wallace_mul8_sequencer.sv
// rtl/wallace_mul8_sequencer.sv - iterative 8x8 multiplier over one shared 4x4 Wallace tree (option macro WALLACE_SEQ_ZERO_SKIP_EN)

// 4x4 unsigned Wallace-tree multiplier: two reduction layers then a final carry-propagate add
module wallace_tree4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [3:0] pp [4];
   logic       s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
   logic [7:0] row_x;
   logic [7:0] row_y;

   // partial product rows: pp[r][c] has weight r+c
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         pp[r] = a & {4{b[r]}};
      end
   end

   // layer 1: trim the tall middle columns (3 and 4) with half adders
   assign {c1, s1} = {pp[0][3] & pp[1][2], pp[0][3] ^ pp[1][2]};
   assign {c2, s2} = {pp[1][3] & pp[2][2], pp[1][3] ^ pp[2][2]};

   // layer 2: full adders bring every column down to two bits
   assign s3 = pp[0][2] ^ pp[1][1] ^ pp[2][0];
   assign c3 = (pp[0][2] & pp[1][1]) | (pp[0][2] & pp[2][0]) | (pp[1][1] & pp[2][0]);
   assign s4 = s1 ^ pp[2][1] ^ pp[3][0];
   assign c4 = (s1 & pp[2][1]) | (s1 & pp[3][0]) | (pp[2][1] & pp[3][0]);
   assign s5 = s2 ^ pp[3][1] ^ c1;
   assign c5 = (s2 & pp[3][1]) | (s2 & c1) | (pp[3][1] & c1);
   assign s6 = pp[2][3] ^ pp[3][2] ^ c2;
   assign c6 = (pp[2][3] & pp[3][2]) | (pp[2][3] & c2) | (pp[3][2] & c2);

   // final two rows and carry-propagate adder
   assign row_x = {1'b0, pp[3][3], s6, s5, s4, s3, pp[0][1], pp[0][0]};
   assign row_y = {1'b0, c6, c5, c4, c3, 1'b0, pp[1][0], 1'b0};
   assign p     = row_x + row_y;
endmodule

module wallace_mul8_sequencer #(
   parameter int OPCNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   wallace_mul8_sequencer_if.slave bus,
   output logic                    busy,
   output logic [OPCNT_W-1:0]      op_count
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [OPCNT_W-1:0] CNT_ONE = 1;
   localparam logic [OPCNT_W-1:0] CNT_MAX = '1;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [15:0] acc;
   logic [1:0]  pass;
   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [7:0]  nib_prod;
   logic [15:0] nib_shifted;
   logic        accept;
   logic        deliver;
   logic        zero_op;
   logic        out_valid_r;
   logic        out_valid_nxt;
   logic        busy_nxt;

   assign bus.in_ready    = (state == ST_IDLE) && !rst;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_product = acc;

   assign accept  = bus.in_valid && bus.in_ready;
   assign deliver = out_valid_r && bus.out_ready;

`ifdef WALLACE_SEQ_ZERO_SKIP_EN
   assign zero_op = (bus.in_a == 8'h00) || (bus.in_b == 8'h00);
`else
   assign zero_op = 1'b0;
`endif

   // the single shared tree instance; only this sequencer drives its operands
   wallace_tree4x4 u_tree (
      .a (nib_a),
      .b (nib_b),
      .p (nib_prod)
   );

   // pick the nibble pair for the current pass and align its product
   always_comb begin
      nib_a       = pass[0] ? a_r[7:4] : a_r[3:0];
      nib_b       = pass[1] ? b_r[7:4] : b_r[3:0];
      nib_shifted = 16'h0000;
      case (pass)
         2'd0:    nib_shifted = {8'h00, nib_prod};
         2'd1:    nib_shifted = {4'h0, nib_prod, 4'h0};
         2'd2:    nib_shifted = {4'h0, nib_prod, 4'h0};
         default: nib_shifted = {nib_prod, 8'h00};
      endcase
   end

   // state register together with the registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         out_valid_r <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         out_valid_r <= out_valid_nxt;
         busy        <= busy_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = zero_op ? ST_DONE : ST_MUL;
            end
         end
         ST_MUL: begin
            if (pass == 2'd3) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (deliver) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // output decode from the upcoming state so the outputs come straight from flops
   always_comb begin
      out_valid_nxt = 1'b0;
      busy_nxt      = 1'b0;
      case (state_nxt)
         ST_MUL: begin
            busy_nxt = 1'b1;
         end
         ST_DONE: begin
            out_valid_nxt = 1'b1;
            busy_nxt      = 1'b1;
         end
         default: begin
            out_valid_nxt = 1'b0;
            busy_nxt      = 1'b0;
         end
      endcase
   end

   // operand capture and per-pass accumulation; acc doubles as the result register
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r  <= 8'h00;
         b_r  <= 8'h00;
         acc  <= 16'h0000;
         pass <= 2'd0;
      end else if (state == ST_IDLE) begin
         if (accept) begin
            a_r  <= bus.in_a;
            b_r  <= bus.in_b;
            acc  <= 16'h0000;
            pass <= 2'd0;
         end
      end else if (state == ST_MUL) begin
         acc  <= acc + nib_shifted;
         pass <= pass + 2'd1;
      end
   end

   // saturating count of delivered results
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (deliver && (op_count != CNT_MAX)) begin
         op_count <= op_count + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_wallace_mul8_sequencer.sv
// tb/tb_wallace_mul8_sequencer.sv - directed self-checking bench for wallace_mul8_sequencer
module tb_wallace_mul8_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic        busy2;
   logic [15:0] op_count;
   logic [1:0]  op_count2;
   int          tests = 0;
   int          fails = 0;
   int          lat;
   int          gap;
   int          exp_zero_lat;

   wallace_mul8_sequencer_if bus ();
   wallace_mul8_sequencer_if bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_a      = bus.in_a;
   assign bus2.in_b      = bus.in_b;
   assign bus2.out_ready = bus.out_ready;

   wallace_mul8_sequencer #(.OPCNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   wallace_mul8_sequencer #(.OPCNT_W(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus2),
      .busy     (busy2),
      .op_count (op_count2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_op(input string tag, input logic [7:0] a, input logic [7:0] b);
      logic seen;
      int   n;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 50) begin
         seen = bus.in_ready;
         tick();
         n++;
      end
      check({tag, "_accepted"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_valid(output int l);
      l = 0;
      while (bus.out_valid !== 1'b1 && l < 50) begin
         tick();
         l++;
      end
   endtask

   initial begin
`ifdef WALLACE_SEQ_ZERO_SKIP_EN
      exp_zero_lat = 0;
`else
      exp_zero_lat = 4;
`endif
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_product", {16'd0, bus.out_product}, 32'h0000);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_op_count", {16'd0, op_count}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // 0xFF * 0xFF
      bus.out_ready = 1'b1;
      accept_op("ff", 8'hFF, 8'hFF);
      bus.in_valid = 1'b0;
      check("ff_busy", {31'd0, busy}, 32'd1);
      check("ff_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      wait_valid(lat);
      check("ff_latency", lat, 32'd4);
      check("ff_product", {16'd0, bus.out_product}, 32'hFE01);
      tick();
      check("ff_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      check("ff_op_count", {16'd0, op_count}, 32'd1);
      check("ff_op_count2", {30'd0, op_count2}, 32'd1);
      check("ff_idle_ready", {31'd0, bus.in_ready}, 32'd1);

      // back-to-back with in_valid held high
      accept_op("b2b1", 8'h12, 8'h34);
      bus.in_a = 8'h0F;
      bus.in_b = 8'h10;
      gap = 0;
      while (bus.in_ready !== 1'b1 && gap < 20) begin
         if (bus.out_valid === 1'b1) begin
            check("b2b_product1", {16'd0, bus.out_product}, 32'h03A8);
         end
         tick();
         gap++;
      end
      check("b2b_accept_gap", gap + 1, 32'd6);
      check("b2b_op_count_a", {16'd0, op_count}, 32'd2);
      check("b2b_op_count2_a", {30'd0, op_count2}, 32'd2);
      accept_op("b2b2", 8'h0F, 8'h10);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("b2b_latency2", lat, 32'd4);
      check("b2b_product2", {16'd0, bus.out_product}, 32'h00F0);
      tick();
      check("b2b_op_count_b", {16'd0, op_count}, 32'd3);
      check("b2b_op_count2_b", {30'd0, op_count2}, 32'd3);

      // 0xA5 * 0x3C with the sink stalling for 10 cycles
      bus.out_ready = 1'b0;
      accept_op("stall", 8'hA5, 8'h3C);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("stall_latency", lat, 32'd4);
      for (int i = 0; i < 10; i++) begin
         check("stall_product", {16'd0, bus.out_product}, 32'h26AC);
         check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
         check("stall_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      check("stall_op_count_held", {16'd0, op_count}, 32'd3);
      bus.out_ready = 1'b1;
      #1;
      check("stall_product_release", {16'd0, bus.out_product}, 32'h26AC);
      tick();
      check("stall_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      check("stall_op_count", {16'd0, op_count}, 32'd4);
      check("stall_op_count2", {30'd0, op_count2}, 32'd3);
      tick();
      check("stall_single_handshake", {16'd0, op_count}, 32'd4);

      // reset during pass2 of 0x80 * 0x80
      accept_op("abort", 8'h80, 8'h80);
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("abort_idle", {31'd0, bus.in_ready}, 32'd1);
      check("abort_product", {16'd0, bus.out_product}, 32'h0000);
      check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_op_count", {16'd0, op_count}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end

      // reset also cleared the counters; rebuild the saturating sequence on dut2
      accept_op("redo", 8'h80, 8'h80);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("redo_latency", lat, 32'd4);
      check("redo_product", {16'd0, bus.out_product}, 32'h4000);
      tick();
      check("redo_op_count", {16'd0, op_count}, 32'd1);
      check("sat_count_1", {30'd0, op_count2}, 32'd1);

      // zero operand
      accept_op("zero", 8'h00, 8'hAB);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("zero_latency", lat, exp_zero_lat);
      check("zero_product", {16'd0, bus.out_product}, 32'h0000);
      tick();
      check("zero_op_count", {16'd0, op_count}, 32'd2);
      check("sat_count_2", {30'd0, op_count2}, 32'd2);

      // three more completions drive the 2-bit counter into saturation
      accept_op("s3", 8'h03, 8'h05);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("s3_product", {16'd0, bus.out_product}, 32'h000F);
      tick();
      check("sat_count_3", {30'd0, op_count2}, 32'd3);

      accept_op("s4", 8'h10, 8'h10);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("s4_product", {16'd0, bus.out_product}, 32'h0100);
      tick();
      check("sat_count_4", {30'd0, op_count2}, 32'd3);

      accept_op("s5", 8'hC3, 8'h07);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("s5_product", {16'd0, bus.out_product}, 32'h0555);
      tick();
      check("sat_count_5", {30'd0, op_count2}, 32'd3);
      check("s5_op_count", {16'd0, op_count}, 32'd5);
      check("busy_match", {31'd0, busy2}, {31'd0, busy});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
